// File: rtl/counter_event_logger.sv
// Edge-detects counter overflow/underflow, stamps events into a small FIFO and keeps saturating stats.
// Optional COUNTER_EVT_BURST_ALARM_EN adds a sticky burst_alarm output.
module counter_event_logger #(
  parameter int CW     = 16,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int STAT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CW-1:0]            counter_value,
  input  logic                     counter_overflow,
  input  logic                     counter_underflow,
  input  logic                     clr_stats,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [1:0]               evt_type,
  output logic [TS_W-1:0]          evt_ts,
  output logic [CW-1:0]            evt_value,
  output logic [STAT_W-1:0]        ovf_count,
  output logic [STAT_W-1:0]        udf_count,
  output logic [STAT_W-1:0]        drop_count,
`ifdef COUNTER_EVT_BURST_ALARM_EN
  output logic                     burst_alarm,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]      typ;
    logic [TS_W-1:0] ts;
    logic [CW-1:0]   val;
  } rec_t;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_prev_q, udf_prev_q;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [STAT_W-1:0] ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d, drop_cnt_q, drop_cnt_d;
  rec_t              mem_q [DEPTH];
  rec_t              rec_d, head;
  logic              ovf_evt, udf_evt, evt, empty, full, pop, push, drop;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + STAT_W'(1) : c;
  endfunction

  always_comb begin
    ts_d    = ts_q + TS_W'(1);
    ovf_evt = counter_overflow & ~ovf_prev_q;
    udf_evt = counter_underflow & ~udf_prev_q;
    evt     = ovf_evt | udf_evt;
    rec_d   = '{typ: {udf_evt, ovf_evt}, ts: ts_q, val: counter_value};
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = ~empty & evt_ready;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    push    = evt & (~full | pop);
    drop    = evt & full & ~pop;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    if (clr_stats) begin
      ovf_cnt_d  = '0;
      udf_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      ovf_cnt_d  = sat_inc(ovf_cnt_q, ovf_evt);
      udf_cnt_d  = sat_inc(udf_cnt_q, udf_evt);
      drop_cnt_d = sat_inc(drop_cnt_q, drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      ovf_prev_q <= 1'b0;
      udf_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_cnt_q  <= '0;
      udf_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      ovf_prev_q <= counter_overflow;
      udf_prev_q <= counter_underflow;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_cnt_q  <= ovf_cnt_d;
      udf_cnt_q  <= udf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rec_d;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q[AW-1:0]];
    evt_valid  = ~empty;
    evt_type   = empty ? 2'b00 : head.typ;
    evt_ts     = empty ? '0 : head.ts;
    evt_value  = empty ? '0 : head.val;
    ovf_count  = ovf_cnt_q;
    udf_count  = udf_cnt_q;
    drop_count = drop_cnt_q;
    fifo_level = wr_ptr_q - rd_ptr_q;
  end

`ifdef COUNTER_EVT_BURST_ALARM_EN
  logic [3:0] win_q, win_d;
  logic [2:0] burst_q, burst_d;
  logic       alarm_q, alarm_d;

  always_comb begin
    win_d   = win_q;
    burst_d = burst_q;
    alarm_d = alarm_q;
    if (clr_stats) begin
      win_d   = '0;
      burst_d = '0;
      alarm_d = 1'b0;
    end else if (evt) begin
      win_d   = 4'd15;
      burst_d = (win_q != 4'd0) ? ((burst_q == 3'd7) ? 3'd7 : burst_q + 3'd1) : 3'd1;
      if (burst_d == 3'd4) alarm_d = 1'b1;
    end else if (win_q != 4'd0) begin
      win_d = win_q - 4'd1;
      if (win_q == 4'd1) burst_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      burst_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      burst_q <= burst_d;
      alarm_q <= alarm_d;
    end
  end

  assign burst_alarm = alarm_q;
`endif
endmodule

// File: doc/counter_event_logger.md
Name: counter_event_logger

Overview:
- Downstream consumer of the 16-bit up/down counter stage.
- Detects rising edges on the counter's overflow and underflow flags.
- Stamps each event with a free-running timestamp and the current counter value, then queues the record in a small FIFO drained over a valid/ready interface.
- Keeps saturating per-type event and drop statistics for debug and security monitoring of counter anomalies.

Parameters:
- CW, 16, width of counter_value input.
- TS_W, 16, timestamp width; timestamp wraps modulo 2^TS_W.
- DEPTH, 8, FIFO depth in records; power of 2, minimum 2.
- STAT_W, 8, width of each saturating statistics counter.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset; assertion is immediate, release is synchronous to clk.
- counter_value  in  CW  counter value from the upstream counter stage.
- counter_overflow  in  1  upstream overflow flag.
- counter_underflow  in  1  upstream underflow flag.
- clr_stats  in  1  synchronous clear of the statistics counters.
- evt_valid  out  1  FIFO head record valid.
- evt_ready  in  1  consumer accepts head record.
- evt_type  out  2  01=overflow, 10=underflow, 11=both in the same cycle.
- evt_ts  out  TS_W  timestamp of head record.
- evt_value  out  CW  counter_value sampled with the event.
- ovf_count  out  STAT_W  overflow events detected, saturating.
- udf_count  out  STAT_W  underflow events detected, saturating.
- drop_count  out  STAT_W  records lost to a full FIFO, saturating.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: all outputs 0, FIFO empty, timestamp 0, edge-detect history registers 0.
- Timestamp: ts increments by 1 every cycle after reset and wraps from 2^TS_W-1 to 0.
- Edge detection: ovf_prev and udf_prev hold the previous-cycle flags. Event in cycle t when flag=1 and prev=0. A flag held high for N cycles produces one event.
- Record in cycle t is {type, ts(t), counter_value(t)}. It is written at the posedge ending cycle t.
- Overflow and underflow rising in the same cycle produce one record with type=11. Both ovf_count and udf_count increment.
- Latency: an event in cycle t into an empty FIFO gives evt_valid=1 in cycle t+1. There is no combinational bypass.
- Handshake: a pop occurs when evt_valid and evt_ready are both 1 at the posedge. evt_type, evt_ts and evt_value stay stable while evt_valid=1 and evt_ready=0. evt_ready while empty has no effect.
- Full FIFO, push only: the record is dropped and drop_count increments. Statistics counters still count the event.
- Full FIFO, push with simultaneous pop: the push is accepted, the level stays DEPTH, and nothing is dropped.
- Empty FIFO with a push: accepted as normal, since no pop is possible.
- Statistics: saturate at 2^STAT_W-1 and never wrap.
- clr_stats: in the cycle it is asserted, all three statistics counters become 0 and that cycle's events are not counted. FIFO contents and logging are unaffected.
- Reset mid-operation: FIFO contents are discarded, evt_valid deasserts immediately, and the timestamp restarts at 0.
- Arithmetic: pointers are log2(DEPTH)+1 bits; full and empty are decided from the MSB comparison.

Optional Feature:
- Macro: COUNTER_EVT_BURST_ALARM_EN.
- When defined:
  - Adds output burst_alarm (1 bit).
  - A 4-bit window counter reloads to 15 on every detected event and counts down to 0 otherwise. A 3-bit burst counter counts events seen while the window is nonzero; it resets to 1 on an event with the window at 0, and to 0 when the window expires.
  - burst_alarm sets (sticky) on the 4th such event, meaning 4 events with each within 15 cycles of the previous one.
  - Cleared only by clr_stats or reset.
- When undefined: the port and logic are absent and all other behaviour is identical.

Test Plan:
- Reset, then one overflow pulse at ts=5 with value=0xFFFF: evt_valid at ts=6, record {01,5,0xFFFF}; ovf_count=1.
- Underflow held high for 4 cycles: exactly one record (type=10) and udf_count=1.
- Overflow and underflow rise in the same cycle with value=0x0000: a single record of type=11; ovf_count=1 and udf_count=1.
- evt_ready=0 with 10 events spaced 2 cycles apart: fifo_level=8 and drop_count=2. Draining gives the first 8 records in order with increasing ts. A push with a pop at full gives no drop.
- Force 300 overflow events: ovf_count=255 (saturated). clr_stats coinciding with an event leaves ovf_count=0 while the record is still logged.
- With COUNTER_EVT_BURST_ALARM_EN defined, 4 events 10 cycles apart set burst_alarm; 4 events 20 cycles apart leave it 0. clr_stats clears it.
